// File: rtl/alu_pkg.sv
// Shared ALU encodings: shift-unit control codes and shift sequencer states.
package alu_pkg;

    // Shift-unit control: one single-bit step per cycle, or pass-through.
    localparam logic [1:0] SH_NONE  = 2'b00;
    localparam logic [1:0] SH_RIGHT = 2'b01;
    localparam logic [1:0] SH_LEFT  = 2'b10;

    // Shift sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } seq_state_e;

    // Map a captured direction bit (1 = left) onto the shift-unit code.
    function automatic logic [1:0] shamt_for_dir(input logic dir_left);
        return dir_left ? SH_LEFT : SH_RIGHT;
    endfunction

endpackage

// File: rtl/shift_unit.sv
// Single-step N-bit shift unit: pass-through, logical right by one or left by one.
// Purely combinational; shared by the ALU datapath and the shift sequencer.
module shift_unit
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] dataa,
    input  logic [1:0]   shamt,
    output logic [N-1:0] dataout
);

    // Select the one-step shift result; the unused code 11 passes data through.
    always_comb begin
        dataout = dataa;
        case (shamt)
            SH_NONE:  dataout = dataa;
            SH_RIGHT: dataout = {1'b0, dataa[N-1:1]};
            SH_LEFT:  dataout = {dataa[N-2:0], 1'b0};
            default:  dataout = dataa;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: drives the external single-step shift unit once
// per clock, folding its result back into an accumulator until the requested
// count is exhausted, then presents the result with a one-cycle done pulse.
module shift_sequencer
    import alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int CNTW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N-1:0]    din,
    input  logic            dir,
    input  logic [CNTW-1:0] count,
    input  logic [N-1:0]    su_dataout,
    output logic [N-1:0]    su_dataa,
    output logic [1:0]      su_shamt,
    output logic [N-1:0]    dout,
    output logic            busy,
    output logic            done
);

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    seq_state_e      state_q, state_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic            dir_q, dir_d;
    logic [N-1:0]    dout_q, dout_d;

    // Next-state and datapath update; operands are captured only when idle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = din;
                    rem_d = count;
                    dir_d = dir;
                    if (count != CNT_ZERO) begin
                        state_d = ST_SHIFT;
                    end else begin
                        // Zero-length shift: result is the operand itself.
                        state_d = ST_DONE;
                        dout_d  = din;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = su_dataout;
                rem_d = rem_q - CNT_ONE;
                if (rem_q == CNT_ONE) begin
                    // Last step: take the shift unit's output straight into dout.
                    dout_d  = su_dataout;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= {N{1'b0}};
            rem_q   <= CNT_ZERO;
            dir_q   <= 1'b0;
            dout_q  <= {N{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
        end
    end

    // Shift-unit control decodes from registered state only, so it never glitches to 11.
    always_comb begin
        su_shamt = SH_NONE;
        case (state_q)
            ST_SHIFT: su_shamt = shamt_for_dir(dir_q);
            ST_IDLE:  su_shamt = SH_NONE;
            ST_DONE:  su_shamt = SH_NONE;
            default:  su_shamt = SH_NONE;
        endcase
    end

    assign su_dataa = acc_q;
    assign dout     = dout_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: shift_sequencer connected back-to-back with shift_unit.
// Stimulus pushes expected results; a negedge monitor pops on every done.
module tb_shift_sequencer;
    import alu_pkg::*;

    localparam int N    = 8;
    localparam int CNTW = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [N-1:0]    din   = 8'h00;
    logic            dir   = 1'b0;
    logic [CNTW-1:0] count = 3'd0;
    logic [N-1:0]    su_dataout;
    logic [N-1:0]    su_dataa;
    logic [1:0]      su_shamt;
    logic [N-1:0]    dout;
    logic            busy;
    logic            done;

    shift_sequencer #(.N(N), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .dir        (dir),
        .count      (count),
        .su_dataout (su_dataout),
        .su_dataa   (su_dataa),
        .su_shamt   (su_shamt),
        .dout       (dout),
        .busy       (busy),
        .done       (done)
    );

    shift_unit #(.N(N)) u_su (
        .dataa   (su_dataa),
        .shamt   (su_shamt),
        .dataout (su_dataout)
    );

    always #5 clk = ~clk;

    // Edge counter used to time done pulses relative to the accepting edge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] d;
        int unsigned  c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor: shamt legality every cycle; on each done, pop and compare result and latency.
    always @(negedge clk) begin
        check("shamt_legal", {31'd0, (su_shamt == 2'b11)}, 32'd0);
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done: done with no pending op, dout=%0h cycle %0d", dout, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("dout", dout, mon_e.d);
                check("done_latency", cyc, mon_e.c);
            end
        end
    end

    // Wait for IDLE, present an operation and let one edge accept it.
    task automatic issue(input logic [N-1:0] d_i, input logic r_i, input logic [CNTW-1:0] c_i);
        int w;
        w = 0;
        while (busy && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (busy) begin
            n_chk++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles", busy, w);
        end
        start = 1'b1;
        din   = d_i;
        dir   = r_i;
        count = c_i;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full operation: push expectation, then watch busy/shamt until done.
    task automatic run_op(input logic [N-1:0] d_i, input logic r_i, input logic [CNTW-1:0] c_i,
                          input logic [N-1:0] e_i, input bit intrude);
        bit got;
        got = 1'b0;
        issue(d_i, r_i, c_i);
        sb.push_back('{d: e_i, c: cyc + c_i});
        n_pushed++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                check("shamt_done", su_shamt, SH_NONE);
                got = 1'b1;
                break;
            end
            check("busy_shift", busy, 1'b1);
            check("shamt_shift", su_shamt, shamt_for_dir(r_i));
            if (intrude && i == 1) begin
                start = 1'b1;
                din   = 8'h00;
                count = 3'd0;
                dir   = ~r_i;
            end else if (intrude && i == 2) begin
                start = 1'b0;
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL done_timeout: no done for din=%0h count=%0d", d_i, c_i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dataa", su_dataa, 8'h00);
        check("rst_shamt", su_shamt, SH_NONE);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: right by 3
        run_op(8'hB4, 1'b0, 3'd3, 8'h16, 1'b0);
        // 2: left by 2
        run_op(8'h81, 1'b1, 3'd2, 8'h04, 1'b0);
        // 3: zero count
        run_op(8'h5A, 1'b0, 3'd0, 8'h5A, 1'b0);
        // 4: maximum count both ways
        run_op(8'hFF, 1'b1, 3'd7, 8'h80, 1'b0);
        run_op(8'hFF, 1'b0, 3'd7, 8'h01, 1'b0);
        // 5: start pulsed mid-operation must be ignored
        run_op(8'hB4, 1'b0, 3'd3, 8'h16, 1'b1);
        repeat (3) @(negedge clk);
        check("no_restart_busy", busy, 1'b0);

        // 6: reset during SHIFT aborts with no done
        issue(8'hFF, 1'b0, 3'd7);
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_dout", dout, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_shamt", su_shamt, SH_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", busy, 1'b0);
        run_op(8'h3C, 1'b1, 3'd1, 8'h78, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        check("done_count", n_done, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
